dw_norm_seq: RTL and testbench

DW_NORM_SEQ -- requirements
Module: dw_norm_seq

---
 rtl/dw_norm_seq.sv | 157 +++++++++++++++
 tb/tb_dw_norm_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dw_norm_seq.sv
// Sequential normalizer. Accepts one word at a time, repeatedly drives an
// external arithmetic left shifter with at most MAXSH positions per cycle
// until the word is normalized, then presents the normalized word with the
// total shift count and a zero flag until downstream accepts it.
module dw_norm_seq #(
    parameter int data_width = 17,
    parameter int sh_width   = 4,
    parameter int exp_width  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [data_width-1:0] in_data,
    input  logic                  in_tc,
    output logic [data_width-1:0] sh_data_in,
    output logic [sh_width-1:0]   sh_amt,
    output logic                  sh_data_tc,
    output logic                  sh_tc,
    output logic                  sh_mode,
    input  logic [data_width-1:0] sh_data_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [data_width-1:0] out_data,
    output logic [exp_width-1:0]  out_exp,
    output logic                  out_zero
);

    localparam int MAXSH  = (1 << sh_width) - 1;
    localparam int LZ_CAP = data_width - 1;

    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

    state_t                state_reg, state_next;
    logic [data_width-1:0] data_reg, data_next;
    logic                  tc_reg, tc_next;
    logic [exp_width-1:0]  exp_reg, exp_next;
    logic                  zero_reg, zero_next;

    logic [data_width-2:0] sign_eq;
    logic                  data_is_zero;
    int                    lz;
    logic                  run;
    logic [sh_width-1:0]   amt;

    // Per-bit flags: bit below the MSB matches the MSB (sign extension bits).
    genvar gi;
    generate
        for (gi = 0; gi < data_width - 1; gi++) begin : g_sign_eq
            assign sign_eq[gi] = (data_reg[gi] == data_reg[data_width-1]);
        end
    endgenerate

    assign data_is_zero = (data_reg == '0);

    // Leading-zero / redundant-sign-bit count of the working word.
    always_comb begin
        lz  = 0;
        run = 1'b1;
        if (tc_reg) begin
            for (int i = data_width - 2; i >= 0; i--) begin
                if (run && sign_eq[i]) begin
                    lz = lz + 1;
                end else begin
                    run = 1'b0;
                end
            end
        end else begin
            for (int i = data_width - 1; i >= 0; i--) begin
                if (run && !data_reg[i]) begin
                    lz = lz + 1;
                end else begin
                    run = 1'b0;
                end
            end
            if (lz > LZ_CAP) begin
                lz = LZ_CAP;
            end
        end
    end

    // Shift applied this cycle: the whole count if it fits the shifter port,
    // otherwise the maximum, with the remainder handled on the next cycle.
    always_comb begin
        if (data_is_zero) begin
            amt = '0;
        end else if (lz > MAXSH) begin
            amt = sh_width'(MAXSH);
        end else begin
            amt = sh_width'(lz);
        end
    end

    // Next-state and datapath-update logic for the IDLE/NORM/DONE sequencer.
    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        tc_next    = tc_reg;
        exp_next   = exp_reg;
        zero_next  = zero_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    data_next  = in_data;
                    tc_next    = in_tc;
                    exp_next   = '0;
                    zero_next  = (in_data == '0);
                    state_next = NORM;
                end
            end
            NORM: begin
                data_next = sh_data_out;
                exp_next  = exp_reg + exp_width'(amt);
                if (data_is_zero || (lz <= MAXSH)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            data_reg  <= '0;
            tc_reg    <= 1'b0;
            exp_reg   <= '0;
            zero_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            tc_reg    <= tc_next;
            exp_reg   <= exp_next;
            zero_reg  <= zero_next;
        end
    end

    assign in_ready   = (state_reg == IDLE);
    assign out_valid  = (state_reg == DONE);
    assign sh_data_in = data_reg;
    assign sh_amt     = (state_reg == NORM) ? amt : '0;
    assign sh_data_tc = tc_reg;
    assign sh_tc      = 1'b0;
    assign sh_mode    = 1'b1;
    assign out_data   = data_reg;
    assign out_exp    = exp_reg;
    assign out_zero   = zero_reg;

endmodule

// File: tb/tb_dw_norm_seq.sv
// Directed plus light random bench for dw_norm_seq with a simple behavioural
// shifter attached and a scoreboard of expected normalization results.
module tb_dw_norm_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [16:0] in_data;
    logic        in_tc;
    logic [16:0] sh_data_in;
    logic [3:0]  sh_amt;
    logic        sh_data_tc;
    logic        sh_tc;
    logic        sh_mode;
    logic [16:0] sh_data_out;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] out_data;
    logic [5:0]  out_exp;
    logic        out_zero;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [16:0] data;
        int          exp;
        logic        zero;
        int          cycles;
        int          amt0;
        int          amt1;
    } exp_t;

    exp_t sb[$];

    dw_norm_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_tc      (in_tc),
        .sh_data_in (sh_data_in),
        .sh_amt     (sh_amt),
        .sh_data_tc (sh_data_tc),
        .sh_tc      (sh_tc),
        .sh_mode    (sh_mode),
        .sh_data_out(sh_data_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_exp    (out_exp),
        .out_zero   (out_zero)
    );

    // Behavioural arithmetic left shifter (left shifts fill with zeros).
    assign sh_data_out = sh_data_in << sh_amt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: shift one bit at a time until normalized.
    function automatic exp_t ref_norm(input logic [16:0] d, input logic tc);
        exp_t        r;
        logic [16:0] v;
        int          e;
        v = d;
        e = 0;
        if (d == 17'h0) begin
            r.zero = 1'b1;
        end else begin
            r.zero = 1'b0;
            if (!tc) begin
                while (!v[16]) begin
                    v = v << 1;
                    e++;
                end
            end else begin
                while (v[16] == v[15] && e < 16) begin
                    v = v << 1;
                    e++;
                end
            end
        end
        r.data   = v;
        r.exp    = e;
        r.cycles = (e <= 15) ? 1 : (e + 14) / 15;
        r.amt0   = (e > 15) ? 15 : e;
        r.amt1   = e - r.amt0;
        return r;
    endfunction

    // Offer one word, follow it through NORM, check it in DONE, then release it.
    task automatic run_word(input logic [16:0] d, input logic tc, input int hold);
        exp_t        e;
        exp_t        got;
        int          n;
        logic [16:0] d_hold;
        logic [5:0]  e_hold;
        e = ref_norm(d, tc);
        sb.push_back(e);
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        in_data  = d;
        in_tc    = tc;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 17'($urandom);
        chk("sh_amt_first", sh_amt, e.amt0);
        chk("sh_data_tc", sh_data_tc, tc);
        chk("in_ready_norm", in_ready, 0);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            if (n == 1) chk("sh_amt_second", sh_amt, e.amt1);
            @(negedge clk);
            n++;
        end
        chk("norm_cycles", n, e.cycles);
        got = sb.pop_front();
        $display("word %05h tc=%0d -> out_data=%05h out_exp=%0d out_zero=%0d cycles=%0d",
                 d, tc, out_data, out_exp, out_zero, n);
        chk("out_data", out_data, got.data);
        chk("out_exp", out_exp, got.exp);
        chk("out_zero", out_zero, got.zero);
        chk("sh_amt_done", sh_amt, 0);
        d_hold = out_data;
        e_hold = out_exp;
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            in_data  = 17'h0abcd;
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_data", out_data, d_hold);
            chk("hold_exp", out_exp, e_hold);
        end
        // in_valid is held high while the result is taken; it must be ignored.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 17'h12345;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("release_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 17'h0;
        in_tc     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_exp", out_exp, 0);
        chk("rst_sh_amt", sh_amt, 0);
        chk("sh_tc_const", sh_tc, 0);
        chk("sh_mode_const", sh_mode, 1);
        rst_n = 1'b1;
        @(negedge clk);

        run_word(17'h00001, 1'b0, 0);
        run_word(17'h1FFFF, 1'b1, 0);
        run_word(17'h00000, 1'b0, 0);
        run_word(17'h10000, 1'b0, 5);
        run_word(17'h00000, 1'b1, 1);
        run_word(17'h00002, 1'b0, 0);
        run_word(17'h00003, 1'b1, 0);
        run_word(17'h10000, 1'b1, 0);
        for (int r = 0; r < 8; r++) begin
            run_word(17'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end

        // Reset asserted in the middle of the first NORM cycle.
        in_valid = 1'b1;
        in_data  = 17'h00001;
        in_tc    = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_rst_data", out_data, 17'h00001);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_out_data", out_data, 0);
        chk("arst_out_exp", out_exp, 0);
        chk("arst_out_zero", out_zero, 0);
        chk("arst_sh_amt", sh_amt, 0);
        chk("arst_sh_data_tc", sh_data_tc, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("post_rst_no_valid", out_valid, 0);
        end
        run_word(17'h00100, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
